stepper_positioner: RTL and testbench

Parametrised closed-count stepper positioner for the rail-control board, the successor of the fixed-table digit-driven stepper driver. It accepts signed absolute target positions over a valid/ready handshake and steps a bipolar motor toward each target at a programmable step rate. It supports full-step and half-step sequencing, optional holding torque and abort. It reports position, busy and a single-cycle done pulse so a sequencer (servo pusher, VGA status) can chain moves.

---
 rtl/stepper_positioner.sv | 159 +++++++++++++++
 tb/tb_stepper_positioner.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_positioner.sv
// Closed-count bipolar stepper positioner: accepts signed absolute targets over
// valid/ready, steps toward them at a programmable tick rate, then settles and pulses done.
module stepper_positioner #(
  parameter int POS_W        = 14,
  parameter int STEP_DIV     = 524288,
  parameter int SETTLE_TICKS = 4,
  parameter bit HOLD         = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tgt_valid,
  output logic                    tgt_ready,
  input  logic signed [POS_W-1:0] tgt_pos,
  input  logic                    half_step,
  input  logic                    abort,
  output logic                    A1,
  output logic                    B1,
  output logic                    A2,
  output logic                    B2,
  output logic signed [POS_W-1:0] pos,
  output logic                    busy,
  output logic                    done
);

  localparam int CNT_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam int SET_W = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_SETTLE,
    S_DONE
  } state_t;

  function automatic logic [3:0] phase_coils(input logic [2:0] p);
    case (p)
      3'd0:    phase_coils = 4'b1000;
      3'd1:    phase_coils = 4'b1100;
      3'd2:    phase_coils = 4'b0100;
      3'd3:    phase_coils = 4'b0110;
      3'd4:    phase_coils = 4'b0010;
      3'd5:    phase_coils = 4'b0011;
      3'd6:    phase_coils = 4'b0001;
      default: phase_coils = 4'b1001;
    endcase
  endfunction

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [SET_W-1:0]         settle_q, settle_d;
  logic [2:0]               p_q, p_d;
  logic signed [POS_W-1:0]  pos_q, pos_d;
  logic signed [POS_W-1:0]  tgt_q, tgt_d;
  logic                     half_q, half_d;
  logic [3:0]               coils_q, coils_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     ready_q, ready_d;

  logic                     tick;
  logic                     accept;
  logic [POS_W:0]           diff;
  logic [2:0]               step_size;
  logic signed [POS_W-1:0]  pos_step;
  logic [2:0]               p_step;

  // NOTE: every signal assigned in this block gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    p_d      = p_q;
    pos_d    = pos_q;
    tgt_d    = tgt_q;
    half_d   = half_q;

    tick   = (cnt_q == CNT_W'(STEP_DIV - 1));
    cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
    accept = tgt_valid && ready_q && (state_q == S_IDLE);

    // Sign-extended by one bit so the difference of two extreme positions cannot wrap.
    diff      = {tgt_q[POS_W-1], tgt_q} - {pos_q[POS_W-1], pos_q};
    step_size = half_q ? 3'd1 : 3'd2;
    pos_step  = diff[POS_W] ? pos_q - POS_W'(1) : pos_q + POS_W'(1);
    p_step    = diff[POS_W] ? p_q - step_size : p_q + step_size;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          tgt_d   = tgt_pos;
          half_d  = half_step;
          state_d = (tgt_pos != pos_q) ? S_MOVE : S_DONE;
        end
      end
      S_MOVE: begin
        if (abort) begin
          settle_d = '0;
          state_d  = S_SETTLE;
        end else if (tick) begin
          pos_d = pos_step;
          p_d   = p_step;
          if (pos_step == tgt_q) begin
            settle_d = '0;
            state_d  = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (tick) begin
          if (settle_q == SET_W'(SETTLE_TICKS - 1)) state_d = S_DONE;
          else settle_d = settle_q + SET_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d == S_MOVE) || (state_d == S_SETTLE);
    done_d  = (state_q == S_DONE);
    ready_d = (state_q == S_IDLE) && !accept;
    coils_d = (HOLD || busy_d) ? phase_coils(p_d) : 4'b0000;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      settle_q <= '0;
      p_q      <= 3'd1;
      pos_q    <= '0;
      tgt_q    <= '0;
      half_q   <= 1'b0;
      coils_q  <= HOLD ? 4'b1100 : 4'b0000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      p_q      <= p_d;
      pos_q    <= pos_d;
      tgt_q    <= tgt_d;
      half_q   <= half_d;
      coils_q  <= coils_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign {A1, B1, A2, B2} = coils_q;
  assign pos       = pos_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign tgt_ready = ready_q;

endmodule

// File: tb/tb_stepper_positioner.sv
// Directed bench for stepper_positioner: expected step/position results are queued when a
// target is issued and compared as the DUT steps and pulses done.
module tb_stepper_positioner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tgt_valid = 1'b0;
  logic signed [13:0] tgt_pos = '0;
  logic half_step = 1'b0;
  logic abort = 1'b0;
  logic tgt_ready, a1, b1, a2, b2, busy, done;
  logic signed [13:0] pos;
  logic h_ready, h_a1, h_b1, h_a2, h_b2, h_busy, h_done;
  logic signed [13:0] h_pos;
  logic x_valid = 1'b0;
  logic signed [13:0] x_tgt = '0;
  logic x_half = 1'b0;
  logic x_abort = 1'b0;
  logic x_ready, x_a1, x_b1, x_a2, x_b2, x_busy, x_done;
  logic signed [13:0] x_pos;

  wire [3:0] coils   = {a1, b1, a2, b2};
  wire [3:0] h_coils = {h_a1, h_b1, h_a2, h_b2};
  wire [3:0] x_coils = {x_a1, x_b1, x_a2, x_b2};

  typedef struct {
    logic signed [13:0] pos;
    logic [3:0]         coils;
  } step_t;

  step_t              exp_q[$];
  logic signed [13:0] done_q[$];
  int n_cmp = 0;
  int n_mis = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) if (done) done_cnt++;

  stepper_positioner #(.POS_W(14), .STEP_DIV(4), .SETTLE_TICKS(2), .HOLD(1'b1)) dut (
    .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
    .tgt_pos(tgt_pos), .half_step(half_step), .abort(abort),
    .A1(a1), .B1(b1), .A2(a2), .B2(b2), .pos(pos), .busy(busy), .done(done));

  stepper_positioner #(.POS_W(14), .STEP_DIV(4), .SETTLE_TICKS(2), .HOLD(1'b0)) dut_h0 (
    .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_ready(h_ready),
    .tgt_pos(tgt_pos), .half_step(half_step), .abort(abort),
    .A1(h_a1), .B1(h_b1), .A2(h_a2), .B2(h_b2), .pos(h_pos), .busy(h_busy), .done(h_done));

  stepper_positioner #(.POS_W(14), .STEP_DIV(2), .SETTLE_TICKS(1), .HOLD(1'b1)) dut_x (
    .clk(clk), .reset(reset), .tgt_valid(x_valid), .tgt_ready(x_ready),
    .tgt_pos(x_tgt), .half_step(x_half), .abort(x_abort),
    .A1(x_a1), .B1(x_b1), .A2(x_a2), .B2(x_b2), .pos(x_pos), .busy(x_busy), .done(x_done));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic void exp_step(input int p, input logic [3:0] c);
    step_t s;
    s.pos   = 14'(p);
    s.coils = c;
    exp_q.push_back(s);
  endfunction

  // Called at a negedge with the target inputs idle; returns just after the accepting edge.
  task automatic send(input int t, input logic h);
    check("ready_before_send", tgt_ready, 1);
    tgt_valid = 1'b1;
    tgt_pos   = 14'(t);
    half_step = h;
    @(posedge clk);
    #1 tgt_valid = 1'b0;
  endtask

  task automatic wait_step(input string tag, output int cyc);
    logic signed [13:0] prev;
    step_t s;
    prev = pos;
    cyc = 0;
    while (pos === prev && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_seen"}, (pos !== prev), 1);
    s = exp_q.pop_front();
    check({tag, "_pos"}, pos, s.pos);
    check({tag, "_coils"}, coils, s.coils);
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_final_pos"}, pos, done_q.pop_front());
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_ready_back"}, tgt_ready, 1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    int d0;
    logic signed [13:0] prev;

    // Reset values
    #12;
    check("rst_pos", pos, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_coils_hold", coils, 4'b1100);
    check("rst_coils_nohold", h_coils, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", tgt_ready, 1);

    // +3 full step: two-coil sequence, one step per 4 clk, single done pulse
    d0 = done_cnt;
    send(3, 1'b0);
    exp_step(1, 4'b0110); exp_step(2, 4'b0011); exp_step(3, 4'b1001);
    done_q.push_back(3);
    @(negedge clk);
    check("busy_rise", busy, 1);
    check("ready_fall", tgt_ready, 0);
    wait_step("fwd1", cyc);
    check("first_step_latency", (cyc >= 1 && cyc <= 4), 1);
    wait_step("fwd2", cyc);
    check("step_period2", cyc, 4);
    wait_step("fwd3", cyc);
    check("step_period3", cyc, 4);
    wait_done("fwd", cyc);
    check("settle_to_done", cyc, 9);
    check("done_count_fwd", done_cnt - d0, 1);
    check("busy_after_fwd", busy, 0);

    // Half step backward to -2 from a fresh reset (p=1)
    pulse_reset();
    send(-2, 1'b1);
    exp_step(-1, 4'b1000); exp_step(-2, 4'b1001);
    done_q.push_back(-2);
    wait_step("back1", cyc);
    wait_step("back2", cyc);
    check("half_step_period", cyc, 4);
    wait_done("back", cyc);

    // Zero-length move
    send(-2, 1'b0);
    @(negedge clk);
    check("zero_done_early", done, 0);
    check("zero_busy1", busy, 0);
    @(negedge clk);
    check("zero_done", done, 1);
    check("zero_busy2", busy, 0);
    check("zero_coils", coils, 4'b1001);
    check("zero_pos", pos, -2);

    // Abort at pos 5 on a long move, then +7 while tgt_valid is held high
    pulse_reset();
    send(100, 1'b0);
    exp_step(1, 4'b0110); exp_step(2, 4'b0011); exp_step(3, 4'b1001);
    exp_step(4, 4'b1100); exp_step(5, 4'b0110);
    done_q.push_back(5);
    for (int i = 0; i < 5; i++) wait_step("long", cyc);
    abort = 1'b1;
    check("nohold_coils_move", h_coils, 4'b0110);
    repeat (6) @(negedge clk);
    check("abort_pos_hold", pos, 5);
    check("abort_busy_settle", busy, 1);
    abort = 1'b0;
    wait_done("abort", cyc);
    send(7, 1'b0);
    tgt_valid = 1'b1;
    tgt_pos   = -14'sd50;
    exp_step(6, 4'b0011); exp_step(7, 4'b1001);
    done_q.push_back(7);
    @(negedge clk);
    check("ready_low_in_move", tgt_ready, 0);
    wait_step("resume1", cyc);
    tgt_valid = 1'b0;
    wait_step("resume2", cyc);
    wait_done("resume", cyc);
    check("nohold_coils_idle", h_coils, 4'b0000);
    check("nohold_pos", h_pos, 7);
    check("hold_coils_idle", coils, 4'b1001);

    // Reset mid-move at pos 4
    pulse_reset();
    send(10, 1'b0);
    exp_step(1, 4'b0110); exp_step(2, 4'b0011); exp_step(3, 4'b1001); exp_step(4, 4'b1100);
    for (int i = 0; i < 4; i++) wait_step("pre_rst", cyc);
    #2 reset = 1'b1;
    #1;
    check("midrst_pos", pos, 0);
    check("midrst_busy", busy, 0);
    check("midrst_coils", coils, 4'b1100);
    check("midrst_coils_nohold", h_coils, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Extreme positions on the fast instance: 0 -> +8191, then toward -8192
    check("x_ready", x_ready, 1);
    x_valid = 1'b1; x_tgt = 14'sd8191; x_half = 1'b1;
    @(posedge clk);
    #1 x_valid = 1'b0;
    cyc = 0;
    while (x_done !== 1'b1 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check("x_done_max", x_done, 1);
    check("x_pos_max", x_pos, 8191);
    check("x_coils_max", x_coils, 4'b1000);
    repeat (2) @(negedge clk);
    x_valid = 1'b1; x_tgt = -14'sd8192;
    @(posedge clk);
    #1 x_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      prev = x_pos;
      cyc = 0;
      while (x_pos === prev && cyc < 16) begin
        @(negedge clk);
        cyc++;
      end
      check("x_step_down", x_pos, 8191 - k);
    end
    x_abort = 1'b1;
    cyc = 0;
    while (x_done !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    x_abort = 1'b0;
    check("x_abort_done", x_done, 1);
    check("x_abort_pos", x_pos, 8188);
    check("x_abort_coils", x_coils, 4'b0011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
